pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_STAGES, default 5: number of pipeline stages; pipeline register i sits between stage i and stage i+1, for i = 0..NUM_STAGES-2.
REQ-002 The module SHALL have parameter MEM_STAGE, default 3: index of the stage owning the data-memory port.
REQ-003 The module SHALL have parameter REDIRECT_STAGE, default 4: index of the stage resolving PC redirects; REDIRECT_STAGE > MEM_STAGE.
REQ-004 The module SHALL have parameter CNT_WIDTH, default 16: width of the performance counters.
REQ-005 The module SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read outstanding this cycle.
- if_resp  in  1  instruction-fetch response.
- mem_req  in  1  data read or write issued by MEM_STAGE.
- mem_resp  in  1  data-memory response.
- load_use  in  1  ID-stage load-use hazard against register 1.
- redirect  in  1  taken branch/jump from REDIRECT_STAGE.
- stall  out  NUM_STAGES-1  hold pipeline register i.
- bubble  out  NUM_STAGES-1  load a NOP into pipeline register i.
- valid  out  NUM_STAGES-1  pipeline register i holds a live instruction.
- pc_load  out  1  PC register update enable.
- mem_kill  out  1  datapath forces data byte-enable to 0 (wrong-path access).
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with any stall bit set.
- flush_count  out  CNT_WIDTH  saturating count of accepted redirects.

Function
REQ-006 Terms: mw = mem_req & ~mem_resp & valid[MEM_STAGE-1]; iw = if_req & ~if_resp.
REQ-007 Priority per cycle SHALL be: redirect, then mw, then load_use, then iw.
REQ-008 In mw: stall[i]=1 for i<MEM_STAGE; bubble[MEM_STAGE]=1; higher registers advance; pc_load=0.
REQ-009 In load_use (no mw): stall[0]=1; bubble[1]=1; pc_load=0.
REQ-010 In iw (no higher event): bubble[0]=1; registers 1 and up advance; pc_load=0.
REQ-011 With no event: pc_load = if_resp; all stall and bubble bits 0.
REQ-012 Valid update SHALL be: next valid[i] = 0 if flushed or bubbled; unchanged if stalled; else valid[i-1] (i>0) or if_resp (i=0).
REQ-013 FSM states SHALL be RUN and DRAIN.
REQ-014 RUN, redirect & ~mw: bubble[i]=1 and valid cleared for i<REDIRECT_STAGE; pc_load=1 same cycle; stay in RUN.
REQ-015 RUN, redirect & mw: valid cleared for i<REDIRECT_STAGE; stall per REQ-008; pc_load=0; go to DRAIN.
REQ-016 DRAIN: mem_kill=1; stall[i]=1 for i<MEM_STAGE; ignore load_use, iw and further redirect.
REQ-017 DRAIN, on mem_resp: pc_load=1; bubble[i]=1 for i<REDIRECT_STAGE; return to RUN.
REQ-018 mem_kill SHALL be 0 in RUN.
REQ-019 stall_cycles SHALL increment on every cycle with any stall bit set (DRAIN included) and hold at all-ones.
REQ-020 flush_count SHALL increment once per accepted redirect (RUN only) and hold at all-ones.
REQ-021 stall, bubble, pc_load and mem_kill SHALL be combinational from inputs, state and valid; valid and counters SHALL be registered.

Reset
REQ-022 On reset: state=RUN; valid=0; both counters=0.
REQ-023 During reset: stall=0, bubble=all ones, pc_load=0, mem_kill=0.
REQ-024 Reset mid-DRAIN SHALL return to RUN next cycle with no pc_load pulse.

Structure
REQ-025 Default parameter values and the FSM state enum SHALL live in lc3b_types.
REQ-026 One sub-module, sat_counter (parametrised width, inc, reset), SHALL implement both counters.

Verification
REQ-027 Reset 2 cycles, then if_resp=1 for 4 cycles -> valid=0000, 0001, 0011, 0111, 1111; pc_load=1 on each of those 4 cycles.
REQ-028 Full pipe, mem_req=1, mem_resp low 3 cycles -> stall=0111 and bubble[3]=1 for 3 cycles; stall_cycles=3.
REQ-029 load_use=1 for 1 cycle -> stall=0001, bubble=0010, pc_load=0; next cycle valid[1]=0.
REQ-030 redirect with mw=0 -> pc_load=1 and bubble=1111 same cycle; next cycle valid=0000; flush_count=1.
REQ-031 redirect during mw, mem_resp 2 cycles later -> mem_kill=1 for 2 cycles; pc_load=1 on the resp cycle; FSM returns to RUN.
REQ-032 CNT_WIDTH=4, hold mw for 20 cycles -> stall_cycles saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared defaults and FSM encoding for the pipeline hazard controller.
// The package name lc3b_types is kept so the rest of the LC-3b codebase can import it.
package lc3b_types;

  localparam int NUM_STAGES_DEF     = 5;
  localparam int MEM_STAGE_DEF      = 3;
  localparam int REDIRECT_STAGE_DEF = 4;
  localparam int CNT_WIDTH_DEF      = 16;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: event inputs from the datapath, pipeline-register
// controls and performance counters back to it.
interface pipeline_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_WIDTH  = 16
);
  logic                  if_req;
  logic                  if_resp;
  logic                  mem_req;
  logic                  mem_resp;
  logic                  load_use;
  logic                  redirect;
  logic [NUM_STAGES-2:0] stall;
  logic [NUM_STAGES-2:0] bubble;
  logic [NUM_STAGES-2:0] valid;
  logic                  pc_load;
  logic                  mem_kill;
  logic [CNT_WIDTH-1:0]  stall_cycles;
  logic [CNT_WIDTH-1:0]  flush_count;

  modport master (
    output if_req, if_resp, mem_req, mem_resp, load_use, redirect,
    input  stall, bubble, valid, pc_load, mem_kill, stall_cycles, flush_count
  );

  modport slave (
    input  if_req, if_resp, mem_req, mem_resp, load_use, redirect,
    output stall, bubble, valid, pc_load, mem_kill, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == '1) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= sat_inc(r_count);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble/flush control for an in-order pipeline, with a DRAIN state that
// waits out a wrong-path data access before the redirect takes effect.
module pipeline_hazard_ctrl
  import lc3b_types::*;
#(
  parameter int NUM_STAGES     = NUM_STAGES_DEF,
  parameter int MEM_STAGE      = MEM_STAGE_DEF,
  parameter int REDIRECT_STAGE = REDIRECT_STAGE_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam int NR = NUM_STAGES - 1;

  function automatic logic [NR-1:0] below(input int n);
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic logic [NR-1:0] at(input int n);
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) m[i] = (i == n);
    return m;
  endfunction

  localparam logic [NR-1:0] BELOW_MEM = below(MEM_STAGE);
  localparam logic [NR-1:0] BELOW_RED = below(REDIRECT_STAGE);
  localparam logic [NR-1:0] AT_MEM    = at(MEM_STAGE);
  localparam logic [NR-1:0] AT_0      = at(0);
  localparam logic [NR-1:0] AT_1      = at(1);

  hz_state_e     r_state, w_state_nxt;
  logic [NR-1:0] r_valid, w_valid_nxt, w_shift;
  logic [NR-1:0] w_stall, w_bubble, w_flush;
  logic          w_pc_load, w_mem_kill, w_flush_inc, w_mw, w_iw;

  assign w_mw    = bus.mem_req & ~bus.mem_resp & r_valid[MEM_STAGE-1];
  assign w_iw    = bus.if_req & ~bus.if_resp;
  assign w_shift = {r_valid[NR-2:0], bus.if_resp};

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = '0;
    w_bubble    = '0;
    w_flush     = '0;
    w_pc_load   = 1'b0;
    w_mem_kill  = 1'b0;
    w_flush_inc = 1'b0;
    if (reset) begin
      w_bubble    = '1;
      w_state_nxt = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.redirect && !w_mw) begin
            w_bubble    = BELOW_RED;
            w_flush     = BELOW_RED;
            w_pc_load   = 1'b1;
            w_flush_inc = 1'b1;
          end else if (bus.redirect) begin
            // The data access cannot be cancelled mid-flight; flush now, load PC once it completes.
            w_flush     = BELOW_RED;
            w_stall     = BELOW_MEM;
            w_bubble    = AT_MEM;
            w_flush_inc = 1'b1;
            w_state_nxt = DRAIN;
          end else if (w_mw) begin
            w_stall  = BELOW_MEM;
            w_bubble = AT_MEM;
          end else if (bus.load_use) begin
            w_stall  = AT_0;
            w_bubble = AT_1;
          end else if (w_iw) begin
            w_bubble = AT_0;
          end else begin
            w_pc_load = bus.if_resp;
          end
        end
        DRAIN: begin
          w_mem_kill = 1'b1;
          w_stall    = BELOW_MEM;
          if (bus.mem_resp) begin
            w_pc_load   = 1'b1;
            w_bubble    = BELOW_RED;
            w_state_nxt = RUN;
          end else begin
            w_bubble = AT_MEM;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    w_valid_nxt = '0;
    for (int i = 0; i < NR; i++) begin
      if (w_flush[i] || w_bubble[i]) begin
        w_valid_nxt[i] = 1'b0;
      end else if (w_stall[i]) begin
        w_valid_nxt[i] = r_valid[i];
      end else begin
        w_valid_nxt[i] = w_shift[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (|w_stall),
    .o_count (bus.stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_flush_inc),
    .o_count (bus.flush_count)
  );

  assign bus.stall    = w_stall;
  assign bus.bubble   = w_bubble;
  assign bus.valid    = r_valid;
  assign bus.pc_load  = w_pc_load;
  assign bus.mem_kill = w_mem_kill;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default build plus a 4-bit-counter build for saturation.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.NUM_STAGES(5), .CNT_WIDTH(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.NUM_STAGES(5), .CNT_WIDTH(4))  bus_b ();

  pipeline_hazard_ctrl #(.NUM_STAGES(5), .MEM_STAGE(3), .REDIRECT_STAGE(4), .CNT_WIDTH(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  pipeline_hazard_ctrl #(.NUM_STAGES(5), .MEM_STAGE(3), .REDIRECT_STAGE(4), .CNT_WIDTH(4)) u_dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    #2;
    n_total++; if (bus_a.stall !== 4'b0000) $display("FAIL rst_stall: got %b want 0000", bus_a.stall); else n_pass++;
    n_total++; if (bus_a.bubble !== 4'b1111) $display("FAIL rst_bubble: got %b want 1111", bus_a.bubble); else n_pass++;
    n_total++; if (bus_a.pc_load !== 1'b0) $display("FAIL rst_pc_load: got %b want 0", bus_a.pc_load); else n_pass++;
    n_total++; if (bus_a.mem_kill !== 1'b0) $display("FAIL rst_mem_kill: got %b want 0", bus_a.mem_kill); else n_pass++;
    n_total++; if (bus_a.valid !== 4'b0000) $display("FAIL rst_valid: got %b want 0000", bus_a.valid); else n_pass++;
    n_total++; if (bus_a.stall_cycles !== 16'd0) $display("FAIL rst_stall_cycles: got %0d want 0", bus_a.stall_cycles); else n_pass++;
    n_total++; if (bus_a.flush_count !== 16'd0) $display("FAIL rst_flush_count: got %0d want 0", bus_a.flush_count); else n_pass++;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_fill();
    logic [3:0] exp_v [4];
    exp_v = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
    for (int k = 0; k < 4; k++) begin
      bus_a.if_resp = 1'b1;
      #2;
      n_total++; if (bus_a.valid !== exp_v[k]) $display("FAIL fill_valid[%0d]: got %b want %b", k, bus_a.valid, exp_v[k]); else n_pass++;
      n_total++; if (bus_a.pc_load !== 1'b1) $display("FAIL fill_pc_load[%0d]: got %b want 1", k, bus_a.pc_load); else n_pass++;
      cyc();
    end
    n_total++; if (bus_a.valid !== 4'b1111) $display("FAIL fill_valid_full: got %b want 1111", bus_a.valid); else n_pass++;
  endtask

  task automatic test_mem_wait();
    bus_a.mem_req  = 1'b1;
    bus_a.mem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_total++; if (bus_a.stall !== 4'b0111) $display("FAIL mw_stall[%0d]: got %b want 0111", k, bus_a.stall); else n_pass++;
      n_total++; if (bus_a.bubble !== 4'b1000) $display("FAIL mw_bubble[%0d]: got %b want 1000", k, bus_a.bubble); else n_pass++;
      n_total++; if (bus_a.pc_load !== 1'b0) $display("FAIL mw_pc_load[%0d]: got %b want 0", k, bus_a.pc_load); else n_pass++;
      cyc();
    end
    n_total++; if (bus_a.stall_cycles !== 16'd3) $display("FAIL mw_stall_cycles: got %0d want 3", bus_a.stall_cycles); else n_pass++;
    n_total++; if (bus_a.valid !== 4'b0111) $display("FAIL mw_valid: got %b want 0111", bus_a.valid); else n_pass++;
    bus_a.mem_resp = 1'b1;
    #2;
    n_total++; if (bus_a.stall !== 4'b0000) $display("FAIL mw_resp_stall: got %b want 0000", bus_a.stall); else n_pass++;
    n_total++; if (bus_a.pc_load !== 1'b1) $display("FAIL mw_resp_pc_load: got %b want 1", bus_a.pc_load); else n_pass++;
    cyc();
    bus_a.mem_req  = 1'b0;
    bus_a.mem_resp = 1'b0;
    n_total++; if (bus_a.valid !== 4'b1111) $display("FAIL mw_resp_valid: got %b want 1111", bus_a.valid); else n_pass++;
    n_total++; if (bus_a.stall_cycles !== 16'd3) $display("FAIL mw_resp_stall_cycles: got %0d want 3", bus_a.stall_cycles); else n_pass++;
  endtask

  task automatic test_load_use();
    bus_a.load_use = 1'b1;
    #2;
    n_total++; if (bus_a.stall !== 4'b0001) $display("FAIL lu_stall: got %b want 0001", bus_a.stall); else n_pass++;
    n_total++; if (bus_a.bubble !== 4'b0010) $display("FAIL lu_bubble: got %b want 0010", bus_a.bubble); else n_pass++;
    n_total++; if (bus_a.pc_load !== 1'b0) $display("FAIL lu_pc_load: got %b want 0", bus_a.pc_load); else n_pass++;
    cyc();
    bus_a.load_use = 1'b0;
    n_total++; if (bus_a.valid[1] !== 1'b0) $display("FAIL lu_valid1: got %b want 0", bus_a.valid[1]); else n_pass++;
    n_total++; if (bus_a.valid !== 4'b1101) $display("FAIL lu_valid: got %b want 1101", bus_a.valid); else n_pass++;
  endtask

  task automatic test_ifetch_wait();
    bus_a.if_req  = 1'b1;
    bus_a.if_resp = 1'b0;
    #2;
    n_total++; if (bus_a.bubble !== 4'b0001) $display("FAIL iw_bubble: got %b want 0001", bus_a.bubble); else n_pass++;
    n_total++; if (bus_a.stall !== 4'b0000) $display("FAIL iw_stall: got %b want 0000", bus_a.stall); else n_pass++;
    n_total++; if (bus_a.pc_load !== 1'b0) $display("FAIL iw_pc_load: got %b want 0", bus_a.pc_load); else n_pass++;
    cyc();
    n_total++; if (bus_a.valid !== 4'b1010) $display("FAIL iw_valid: got %b want 1010", bus_a.valid); else n_pass++;
    bus_a.load_use = 1'b1;
    #2;
    n_total++; if (bus_a.stall !== 4'b0001) $display("FAIL prio_lu_stall: got %b want 0001", bus_a.stall); else n_pass++;
    n_total++; if (bus_a.bubble !== 4'b0010) $display("FAIL prio_lu_bubble: got %b want 0010", bus_a.bubble); else n_pass++;
    cyc();
    bus_a.load_use = 1'b0;
    bus_a.if_req   = 1'b0;
    bus_a.if_resp  = 1'b1;
    n_total++; if (bus_a.valid !== 4'b0100) $display("FAIL prio_valid: got %b want 0100", bus_a.valid); else n_pass++;
    n_total++; if (bus_a.stall_cycles !== 16'd5) $display("FAIL prio_stall_cycles: got %0d want 5", bus_a.stall_cycles); else n_pass++;
  endtask

  task automatic test_redirect();
    bus_a.redirect = 1'b1;
    #2;
    n_total++; if (bus_a.pc_load !== 1'b1) $display("FAIL rd_pc_load: got %b want 1", bus_a.pc_load); else n_pass++;
    n_total++; if (bus_a.bubble !== 4'b1111) $display("FAIL rd_bubble: got %b want 1111", bus_a.bubble); else n_pass++;
    n_total++; if (bus_a.stall !== 4'b0000) $display("FAIL rd_stall: got %b want 0000", bus_a.stall); else n_pass++;
    n_total++; if (bus_a.mem_kill !== 1'b0) $display("FAIL rd_mem_kill: got %b want 0", bus_a.mem_kill); else n_pass++;
    cyc();
    bus_a.redirect = 1'b0;
    n_total++; if (bus_a.valid !== 4'b0000) $display("FAIL rd_valid: got %b want 0000", bus_a.valid); else n_pass++;
    n_total++; if (bus_a.flush_count !== 16'd1) $display("FAIL rd_flush_count: got %0d want 1", bus_a.flush_count); else n_pass++;
  endtask

  task automatic test_redirect_drain();
    bus_a.if_resp = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    n_total++; if (bus_a.valid !== 4'b1111) $display("FAIL dr_refill_valid: got %b want 1111", bus_a.valid); else n_pass++;
    bus_a.mem_req  = 1'b1;
    bus_a.mem_resp = 1'b0;
    bus_a.redirect = 1'b1;
    #2;
    n_total++; if (bus_a.pc_load !== 1'b0) $display("FAIL dr_accept_pc_load: got %b want 0", bus_a.pc_load); else n_pass++;
    n_total++; if (bus_a.stall !== 4'b0111) $display("FAIL dr_accept_stall: got %b want 0111", bus_a.stall); else n_pass++;
    n_total++; if (bus_a.bubble !== 4'b1000) $display("FAIL dr_accept_bubble: got %b want 1000", bus_a.bubble); else n_pass++;
    n_total++; if (bus_a.mem_kill !== 1'b0) $display("FAIL dr_accept_mem_kill: got %b want 0", bus_a.mem_kill); else n_pass++;
    cyc();
    n_total++; if (bus_a.valid !== 4'b0000) $display("FAIL dr_valid: got %b want 0000", bus_a.valid); else n_pass++;
    bus_a.load_use = 1'b1;
    #2;
    n_total++; if (bus_a.mem_kill !== 1'b1) $display("FAIL dr_wait_mem_kill: got %b want 1", bus_a.mem_kill); else n_pass++;
    n_total++; if (bus_a.pc_load !== 1'b0) $display("FAIL dr_wait_pc_load: got %b want 0", bus_a.pc_load); else n_pass++;
    n_total++; if (bus_a.stall !== 4'b0111) $display("FAIL dr_wait_stall: got %b want 0111", bus_a.stall); else n_pass++;
    n_total++; if (bus_a.bubble !== 4'b1000) $display("FAIL dr_wait_bubble: got %b want 1000", bus_a.bubble); else n_pass++;
    cyc();
    bus_a.redirect = 1'b0;
    bus_a.load_use = 1'b0;
    bus_a.mem_resp = 1'b1;
    #2;
    n_total++; if (bus_a.mem_kill !== 1'b1) $display("FAIL dr_resp_mem_kill: got %b want 1", bus_a.mem_kill); else n_pass++;
    n_total++; if (bus_a.pc_load !== 1'b1) $display("FAIL dr_resp_pc_load: got %b want 1", bus_a.pc_load); else n_pass++;
    n_total++; if (bus_a.bubble !== 4'b1111) $display("FAIL dr_resp_bubble: got %b want 1111", bus_a.bubble); else n_pass++;
    cyc();
    bus_a.mem_req  = 1'b0;
    bus_a.mem_resp = 1'b0;
    n_total++; if (bus_a.flush_count !== 16'd2) $display("FAIL dr_flush_count: got %0d want 2", bus_a.flush_count); else n_pass++;
    n_total++; if (bus_a.stall_cycles !== 16'd8) $display("FAIL dr_stall_cycles: got %0d want 8", bus_a.stall_cycles); else n_pass++;
    #2;
    n_total++; if (bus_a.mem_kill !== 1'b0) $display("FAIL dr_run_mem_kill: got %b want 0", bus_a.mem_kill); else n_pass++;
    n_total++; if (bus_a.pc_load !== 1'b1) $display("FAIL dr_run_pc_load: got %b want 1", bus_a.pc_load); else n_pass++;
    cyc();
  endtask

  task automatic test_reset_in_drain();
    cyc();
    cyc();
    n_total++; if (bus_a.valid !== 4'b0111) $display("FAIL rdr_valid: got %b want 0111", bus_a.valid); else n_pass++;
    bus_a.if_resp  = 1'b0;
    bus_a.mem_req  = 1'b1;
    bus_a.redirect = 1'b1;
    #2;
    n_total++; if (bus_a.stall !== 4'b0111) $display("FAIL rdr_accept_stall: got %b want 0111", bus_a.stall); else n_pass++;
    cyc();
    bus_a.redirect = 1'b0;
    #2;
    n_total++; if (bus_a.mem_kill !== 1'b1) $display("FAIL rdr_drain_mem_kill: got %b want 1", bus_a.mem_kill); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (bus_a.stall !== 4'b0000) $display("FAIL rdr_rst_stall: got %b want 0000", bus_a.stall); else n_pass++;
    n_total++; if (bus_a.bubble !== 4'b1111) $display("FAIL rdr_rst_bubble: got %b want 1111", bus_a.bubble); else n_pass++;
    n_total++; if (bus_a.pc_load !== 1'b0) $display("FAIL rdr_rst_pc_load: got %b want 0", bus_a.pc_load); else n_pass++;
    n_total++; if (bus_a.mem_kill !== 1'b0) $display("FAIL rdr_rst_mem_kill: got %b want 0", bus_a.mem_kill); else n_pass++;
    cyc();
    reset = 1'b0;
    bus_a.mem_resp = 1'b1;
    n_total++; if (bus_a.valid !== 4'b0000) $display("FAIL rdr_post_valid: got %b want 0000", bus_a.valid); else n_pass++;
    n_total++; if (bus_a.stall_cycles !== 16'd0) $display("FAIL rdr_post_stall_cycles: got %0d want 0", bus_a.stall_cycles); else n_pass++;
    n_total++; if (bus_a.flush_count !== 16'd0) $display("FAIL rdr_post_flush_count: got %0d want 0", bus_a.flush_count); else n_pass++;
    #2;
    n_total++; if (bus_a.mem_kill !== 1'b0) $display("FAIL rdr_post_mem_kill: got %b want 0", bus_a.mem_kill); else n_pass++;
    n_total++; if (bus_a.pc_load !== 1'b0) $display("FAIL rdr_post_pc_load: got %b want 0", bus_a.pc_load); else n_pass++;
    cyc();
    bus_a.mem_req  = 1'b0;
    bus_a.mem_resp = 1'b0;
  endtask

  task automatic test_saturate();
    bus_b.if_resp = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    n_total++; if (bus_b.valid !== 4'b0111) $display("FAIL sat_fill_valid: got %b want 0111", bus_b.valid); else n_pass++;
    bus_b.if_resp  = 1'b0;
    bus_b.mem_req  = 1'b1;
    bus_b.mem_resp = 1'b0;
    for (int k = 0; k < 14; k++) cyc();
    n_total++; if (bus_b.stall_cycles !== 4'd14) $display("FAIL sat_count14: got %0d want 14", bus_b.stall_cycles); else n_pass++;
    for (int k = 0; k < 6; k++) cyc();
    n_total++; if (bus_b.stall_cycles !== 4'd15) $display("FAIL sat_count_hold: got %0d want 15", bus_b.stall_cycles); else n_pass++;
    #2;
    n_total++; if (bus_b.stall !== 4'b0111) $display("FAIL sat_stall: got %b want 0111", bus_b.stall); else n_pass++;
    cyc();
    bus_b.mem_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus_a.if_req   = 1'b0;
    bus_a.if_resp  = 1'b0;
    bus_a.mem_req  = 1'b0;
    bus_a.mem_resp = 1'b0;
    bus_a.load_use = 1'b0;
    bus_a.redirect = 1'b0;
    bus_b.if_req   = 1'b0;
    bus_b.if_resp  = 1'b0;
    bus_b.mem_req  = 1'b0;
    bus_b.mem_resp = 1'b0;
    bus_b.load_use = 1'b0;
    bus_b.redirect = 1'b0;
    test_reset();
    test_fill();
    test_mem_wait();
    test_load_use();
    test_ifetch_wait();
    test_redirect();
    test_redirect_drain();
    test_reset_in_drain();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
